// File: rtl/matrix_multiply_sequencer_if.sv
// Bus bundle between the matmul sequencer and its neighbours: instruction
// decoder, weight FIFO, MMU control, unified buffer read port and
// accumulator write port. With MMU_SEQ_PERF_EN defined the bundle also
// carries the two performance counters.
interface matrix_multiply_sequencer_if #(
  parameter int BUFFER_ADDR_WIDTH = 24,
  parameter int ACC_ADDR_WIDTH    = 16,
  parameter int LENGTH_WIDTH      = 32
);
  // Instruction handshake
  logic                         instr_valid;
  logic                         instr_ready;
  logic [BUFFER_ADDR_WIDTH-1:0] instr_buffer_addr;
  logic [ACC_ADDR_WIDTH-1:0]    instr_acc_addr;
  logic [LENGTH_WIDTH-1:0]      instr_length;
  logic                         instr_signed;
  logic                         instr_accumulate;
  logic                         instr_reuse_weights;
  // Weight FIFO
  logic                         weight_valid;
  logic                         weight_ready;
  // MMU control
  logic                         load_weight;
  logic [7:0]                   weight_addr;
  logic                         activate_weight;
  logic                         mmu_enable;
  logic                         systolic_signed;
  // Unified buffer read port
  logic                         buffer_read_en;
  logic [BUFFER_ADDR_WIDTH-1:0] buffer_read_addr;
  // Accumulator write port
  logic                         acc_write_en;
  logic [ACC_ADDR_WIDTH-1:0]    acc_addr;
  logic                         acc_accumulate;
  // Status
  logic                         busy;
  logic                         done;
`ifdef MMU_SEQ_PERF_EN
  logic [31:0]                  perf_busy_cycles;
  logic [31:0]                  perf_stall_cycles;
`endif

  // Environment side: decoder, weight FIFO, MMU, buffers.
  modport master (
    output instr_valid, instr_buffer_addr, instr_acc_addr, instr_length,
           instr_signed, instr_accumulate, instr_reuse_weights, weight_valid,
    input  instr_ready, weight_ready, load_weight, weight_addr, activate_weight,
           mmu_enable, systolic_signed, buffer_read_en, buffer_read_addr,
           acc_write_en, acc_addr, acc_accumulate, busy, done
`ifdef MMU_SEQ_PERF_EN
    , input perf_busy_cycles, perf_stall_cycles
`endif
  );

  // Sequencer side.
  modport slave (
    input  instr_valid, instr_buffer_addr, instr_acc_addr, instr_length,
           instr_signed, instr_accumulate, instr_reuse_weights, weight_valid,
    output instr_ready, weight_ready, load_weight, weight_addr, activate_weight,
           mmu_enable, systolic_signed, buffer_read_en, buffer_read_addr,
           acc_write_en, acc_addr, acc_accumulate, busy, done
`ifdef MMU_SEQ_PERF_EN
    , output perf_busy_cycles, perf_stall_cycles
`endif
  );
endinterface

// File: rtl/matrix_multiply_sequencer.sv
// Per-instruction controller for the matrix multiply unit. One accepted
// instruction runs weight preload, weight activation, row streaming from the
// unified buffer, and finally tagged accumulator writes that emerge from a
// RESULT_LATENCY-deep delay line matching the MMU pipeline.
// Optional: define MMU_SEQ_PERF_EN to add saturating busy/stall counters.
module matrix_multiply_sequencer #(
  parameter int MATRIX_WIDTH      = 14,
  parameter int BUFFER_ADDR_WIDTH = 24,
  parameter int ACC_ADDR_WIDTH    = 16,
  parameter int LENGTH_WIDTH      = 32,
  parameter int RESULT_LATENCY    = 2*MATRIX_WIDTH+2
) (
  input logic                        clk,
  input logic                        rst,
  matrix_multiply_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, DRAIN} state_t;

  typedef struct packed {
    logic                      valid;
    logic [ACC_ADDR_WIDTH-1:0] addr;
    logic                      accumulate;
  } tag_t;

  localparam logic [7:0] LAST_ROW = 8'(MATRIX_WIDTH - 1);

  state_t                       state_q, state_d;
  logic [7:0]                   k_q;
  logic [LENGTH_WIDTH-1:0]      r_q;
  logic [LENGTH_WIDTH-1:0]      len_q;
  logic [BUFFER_ADDR_WIDTH-1:0] buf_base_q;
  logic [ACC_ADDR_WIDTH-1:0]    acc_base_q;
  logic                         signed_q;
  logic                         accum_q;
  logic                         loaded_q;
  logic                         first_q;

  tag_t                         line_q [RESULT_LATENCY];
  tag_t                         push_tag;
  logic                         line_busy;

  logic accept;
  logic weight_hs;
  logic read_en;

  assign accept    = (state_q == IDLE) && bus.instr_valid;
  assign weight_hs = (state_q == LOAD_W) && bus.weight_valid;
  assign read_en   = (state_q == COMPUTE);

  // Any result still in flight through the MMU pipeline keeps DRAIN alive.
  always_comb begin
    line_busy = 1'b0;
    for (int i = 0; i < RESULT_LATENCY; i++) line_busy |= line_q[i].valid;
  end

  // Next-state and all sequencer outputs, decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d              = state_q;
    bus.instr_ready      = 1'b0;
    bus.weight_ready     = 1'b0;
    bus.load_weight      = 1'b0;
    bus.weight_addr      = '0;
    bus.activate_weight  = 1'b0;
    bus.mmu_enable       = 1'b0;
    bus.systolic_signed  = 1'b0;
    bus.buffer_read_en   = 1'b0;
    bus.buffer_read_addr = '0;
    bus.done             = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          if (!bus.instr_reuse_weights)   state_d = LOAD_W;
          else if (bus.instr_length == '0) state_d = DRAIN;
          else                             state_d = COMPUTE;
        end
      end
      LOAD_W: begin
        bus.weight_ready = 1'b1;
        bus.load_weight  = bus.weight_valid;
        bus.weight_addr  = k_q;
        if (bus.weight_valid && k_q == LAST_ROW)
          state_d = (len_q == '0) ? DRAIN : COMPUTE;
      end
      COMPUTE: begin
        bus.mmu_enable       = 1'b1;
        bus.systolic_signed  = signed_q;
        bus.activate_weight  = first_q && loaded_q;
        bus.buffer_read_en   = 1'b1;
        bus.buffer_read_addr = buf_base_q + BUFFER_ADDR_WIDTH'(r_q);
        if (r_q == len_q - LENGTH_WIDTH'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        bus.mmu_enable = 1'b1;
        if (!line_busy) begin
          bus.done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q != IDLE);

  // State register, instruction latch and the weight-row / systolic-row counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      r_q        <= '0;
      len_q      <= '0;
      buf_base_q <= '0;
      acc_base_q <= '0;
      signed_q   <= 1'b0;
      accum_q    <= 1'b0;
      loaded_q   <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      if (accept) begin
        len_q      <= bus.instr_length;
        buf_base_q <= bus.instr_buffer_addr;
        acc_base_q <= bus.instr_acc_addr;
        signed_q   <= bus.instr_signed;
        accum_q    <= bus.instr_accumulate;
        loaded_q   <= !bus.instr_reuse_weights;
        first_q    <= 1'b1;
        k_q        <= '0;
        r_q        <= '0;
      end
      if (weight_hs) k_q <= (k_q == LAST_ROW) ? '0 : k_q + 8'd1;
      if (read_en) begin
        r_q     <= r_q + LENGTH_WIDTH'(1);
        first_q <= 1'b0;
      end
    end
  end

  // Tag pushed with each buffer read; bubbles carry an all-zero tag.
  always_comb begin
    push_tag            = '0;
    push_tag.valid      = read_en;
    push_tag.addr       = read_en ? acc_base_q + ACC_ADDR_WIDTH'(r_q) : '0;
    push_tag.accumulate = read_en && accum_q;
  end

  // Delay line aligning each read's tag with its result leaving the MMU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: this storage is reset on purpose: a stale valid bit would fire a
      // spurious accumulator write after an aborted instruction.
      for (int i = 0; i < RESULT_LATENCY; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= push_tag;
      for (int i = 1; i < RESULT_LATENCY; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign bus.acc_write_en   = line_q[RESULT_LATENCY-1].valid;
  assign bus.acc_addr       = line_q[RESULT_LATENCY-1].addr;
  assign bus.acc_accumulate = line_q[RESULT_LATENCY-1].accumulate;

`ifdef MMU_SEQ_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;

  // Saturating counters of busy cycles and of weight-FIFO starvation cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (state_q != IDLE && perf_busy_q != '1) perf_busy_q <= perf_busy_q + 32'd1;
      if (state_q == LOAD_W && !bus.weight_valid && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_busy_cycles  = perf_busy_q;
  assign bus.perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_matrix_multiply_sequencer.sv
// Self-checking bench for matrix_multiply_sequencer (MATRIX_WIDTH=4,
// RESULT_LATENCY=10). The whole run is planned up front: per cycle, the
// inputs to drive and the outputs the instruction-level rules predict.
// A single monitor compares every cycle; literal checks pin key scenarios.
module tb_matrix_multiply_sequencer;
  localparam int MW = 4, LAT = 10, BW = 24, AW = 16, LW = 32, MAXC = 2000;

  typedef struct {
    bit          rst;
    bit          iv;
    bit [BW-1:0] ib;
    bit [AW-1:0] ia;
    bit [LW-1:0] il;
    bit          is, iacc, ireuse;
    bit          wv;
  } drv_t;

  typedef struct {
    bit          instr_ready, weight_ready, load_weight;
    bit [7:0]    weight_addr;
    bit          activate, mmu, sgn, rd;
    bit [BW-1:0] rd_addr;
    bit          wr;
    bit [AW-1:0] wr_addr;
    bit          wr_acc;
    bit          busy, done;
    int          perf_busy, perf_stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  matrix_multiply_sequencer_if #(.BUFFER_ADDR_WIDTH(BW), .ACC_ADDR_WIDTH(AW),
                                 .LENGTH_WIDTH(LW)) bus ();

  matrix_multiply_sequencer #(
    .MATRIX_WIDTH(MW), .BUFFER_ADDR_WIDTH(BW), .ACC_ADDR_WIDTH(AW),
    .LENGTH_WIDTH(LW), .RESULT_LATENCY(LAT)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  drv_t dv [MAXC];
  exp_t ex [MAXC];
  int   pc;
  int   cur = -1;
  bit   mon_on = 1'b0;
  int   checks = 0, failures = 0;

  logic          act_ld [MAXC], act_act [MAXC], act_rd [MAXC], act_wr [MAXC];
  logic          act_done [MAXC], act_ready [MAXC], act_stall [MAXC], act_busy [MAXC];
  logic [7:0]    act_waddr [MAXC];
  logic [BW-1:0] act_rdaddr [MAXC];
  logic [AW-1:0] act_wraddr [MAXC];
  logic [31:0]   act_pbusy [MAXC], act_pstall [MAXC];

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, expv);
    end
  endtask

  // ---------------- planning (reference model) ----------------
  task automatic busy_cycle(input int c);
    ex[c].instr_ready = 1'b0;
    ex[c].busy        = 1'b1;
    dv[c].iv          = 1'($urandom_range(0, 1));
  endtask

  task automatic plan_instr(input bit [BW-1:0] b, input bit [AW-1:0] a, input int len,
                            input bit sg, input bit acc, input bit reuse,
                            input int st0, input int st1, input int st2, input int st3,
                            input int abort_r, input int gap,
                            output int acc_c, output int done_c);
    int st [4];
    int j, last;
    st = '{st0, st1, st2, st3};
    pc += gap;
    acc_c = pc;
    dv[pc].iv = 1'b1; dv[pc].ib = b; dv[pc].ia = a; dv[pc].il = LW'(len);
    dv[pc].is = sg; dv[pc].iacc = acc; dv[pc].ireuse = reuse;
    j = pc + 1;
    if (!reuse) begin
      for (int k = 0; k < MW; k++) begin
        for (int s = 0; s < st[k]; s++) begin
          busy_cycle(j);
          ex[j].weight_ready = 1'b1; ex[j].weight_addr = 8'(k); dv[j].wv = 1'b0;
          j++;
        end
        busy_cycle(j);
        ex[j].weight_ready = 1'b1; ex[j].load_weight = 1'b1;
        ex[j].weight_addr = 8'(k); dv[j].wv = 1'b1;
        j++;
      end
    end
    if (len == 0) begin
      busy_cycle(j);
      ex[j].mmu = 1'b1; ex[j].done = 1'b1;
      done_c = j; pc = j + 1;
      return;
    end
    for (int r = 0; r < len; r++) begin
      busy_cycle(j);
      if (r == abort_r) begin
        dv[j].rst = 1'b0; dv[j+1].rst = 1'b0;
        ex[j] = '{default: 0}; ex[j].instr_ready = 1'b1;
        done_c = -1; pc = j + 2;
        return;
      end
      ex[j].mmu = 1'b1; ex[j].sgn = sg; ex[j].rd = 1'b1;
      ex[j].activate = (r == 0) && !reuse;
      ex[j].rd_addr = b + BW'(r);
      if (abort_r < 0) begin
        ex[j+LAT].wr = 1'b1; ex[j+LAT].wr_addr = a + AW'(r); ex[j+LAT].wr_acc = acc;
      end
      j++;
    end
    last = j - 1;
    for (int c = j; c <= last + LAT; c++) begin
      busy_cycle(c);
      ex[c].mmu = 1'b1;
    end
    done_c = last + LAT + 1;
    busy_cycle(done_c);
    ex[done_c].mmu = 1'b1; ex[done_c].done = 1'b1;
    pc = done_c + 1;
  endtask

  function automatic int cnt(input int sel, input int lo, input int hi);
    int n = 0;
    logic v;
    for (int c = lo; c <= hi; c++) begin
      case (sel)
        0: v = act_ld[c];
        1: v = act_rd[c];
        2: v = act_wr[c];
        3: v = act_done[c];
        4: v = act_stall[c];
        5: v = act_act[c];
        default: v = act_busy[c];
      endcase
      if (v === 1'b1) n++;
    end
    return n;
  endfunction

  function automatic int first_cycle(input int sel, input int lo, input int hi);
    for (int c = lo; c <= hi; c++)
      if ((sel == 1 ? act_rd[c] : act_wr[c]) === 1'b1) return c;
    return -1;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (mon_on && cur >= 0) begin
      act_ld[cur] = bus.load_weight;       act_act[cur] = bus.activate_weight;
      act_rd[cur] = bus.buffer_read_en;    act_wr[cur] = bus.acc_write_en;
      act_done[cur] = bus.done;            act_ready[cur] = bus.instr_ready;
      act_stall[cur] = bus.weight_ready & ~bus.weight_valid;
      act_busy[cur] = bus.busy;            act_waddr[cur] = bus.weight_addr;
      act_rdaddr[cur] = bus.buffer_read_addr;
      act_wraddr[cur] = bus.acc_addr;
`ifdef MMU_SEQ_PERF_EN
      act_pbusy[cur] = bus.perf_busy_cycles;
      act_pstall[cur] = bus.perf_stall_cycles;
      check("perf_busy_cycles", cur, bus.perf_busy_cycles, ex[cur].perf_busy);
      check("perf_stall_cycles", cur, bus.perf_stall_cycles, ex[cur].perf_stall);
`else
      act_pbusy[cur] = '0;
      act_pstall[cur] = '0;
`endif
      check("instr_ready", cur, bus.instr_ready, ex[cur].instr_ready);
      check("weight_ready", cur, bus.weight_ready, ex[cur].weight_ready);
      check("load_weight", cur, bus.load_weight, ex[cur].load_weight);
      check("activate_weight", cur, bus.activate_weight, ex[cur].activate);
      check("mmu_enable", cur, bus.mmu_enable, ex[cur].mmu);
      check("buffer_read_en", cur, bus.buffer_read_en, ex[cur].rd);
      check("acc_write_en", cur, bus.acc_write_en, ex[cur].wr);
      check("busy", cur, bus.busy, ex[cur].busy);
      check("done", cur, bus.done, ex[cur].done);
      if (ex[cur].weight_ready || !dv[cur].rst)
        check("weight_addr", cur, bus.weight_addr, ex[cur].weight_addr);
      if (ex[cur].rd || !dv[cur].rst) begin
        check("buffer_read_addr", cur, bus.buffer_read_addr, ex[cur].rd_addr);
        check("systolic_signed", cur, bus.systolic_signed, ex[cur].sgn);
      end
      if (ex[cur].wr || !dv[cur].rst) begin
        check("acc_addr", cur, bus.acc_addr, ex[cur].wr_addr);
        check("acc_accumulate", cur, bus.acc_accumulate, ex[cur].wr_acc);
      end
    end
  end

  // ---------------- main ----------------
  initial begin
    int a1, d1, a2, d2, a3, d3, a4, d4, a5, d5, a6, d6, ar, dr, nc, pb, ps;
    for (int c = 0; c < MAXC; c++) begin
      ex[c] = '{default: 0};
      ex[c].instr_ready = 1'b1;
      dv[c].rst = 1'b1; dv[c].iv = 1'b0;
      dv[c].ib = BW'($urandom); dv[c].ia = AW'($urandom); dv[c].il = $urandom;
      dv[c].is = 1'($urandom); dv[c].iacc = 1'($urandom); dv[c].ireuse = 1'($urandom);
      dv[c].wv = 1'($urandom);
    end
    for (int c = 0; c < 3; c++) dv[c].rst = 1'b0;
    pc = 3;

    plan_instr(24'h100, 16'h20, 3, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, -1, 1, a1, d1);
    plan_instr(24'h100, 16'h20, 3, 1'b1, 1'b1, 1'b0, 0, 3, 0, 0, -1, 2, a2, d2);
    plan_instr(24'hFFFFFF, 16'hFFFF, 2, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, -1, 0, a3, d3);
    plan_instr(24'h55, 16'h5, 0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, -1, 0, a4, d4);
    plan_instr(24'h77, 16'h7, 0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, -1, 1, a6, d6);
    plan_instr(24'h40, 16'h8, 4, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1, 2, a5, d5);
    for (int i = 0; i < 14; i++) begin
      int s [4];
      for (int k = 0; k < 4; k++)
        s[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      plan_instr(BW'($urandom), AW'($urandom), int'($urandom_range(0, 12)),
                 1'($urandom), 1'($urandom), 1'($urandom), s[0], s[1], s[2], s[3],
                 -1, (i == 0) ? 25 : int'($urandom_range(0, 3)), ar, dr);
    end
    nc = pc + 5;

    // Expected performance counters: busy and starved cycles since last reset.
    pb = 0; ps = 0;
    for (int c = 0; c < nc; c++) begin
      if (!dv[c].rst) begin pb = 0; ps = 0; end
      ex[c].perf_busy = pb; ex[c].perf_stall = ps;
      if (dv[c].rst) begin
        if (ex[c].busy) pb++;
        if (ex[c].weight_ready && !dv[c].wv) ps++;
      end
    end

    mon_on = 1'b1;
    for (int c = 0; c < nc; c++) begin
      @(posedge clk);
      #1;
      cur = c;
      rst = dv[c].rst;
      bus.instr_valid = dv[c].iv;           bus.instr_buffer_addr = dv[c].ib;
      bus.instr_acc_addr = dv[c].ia;        bus.instr_length = dv[c].il;
      bus.instr_signed = dv[c].is;          bus.instr_accumulate = dv[c].iacc;
      bus.instr_reuse_weights = dv[c].ireuse;
      bus.weight_valid = dv[c].wv;
    end
    @(negedge clk);
    #1;
    mon_on = 1'b0;

    // Scenario 1: plain load, 3 rows.
    check("s1_load_count", a1, cnt(0, a1, a1 + 5), 4);
    check("s1_waddr_last", a1 + 4, act_waddr[a1 + 4], 3);
    check("s1_activate", a1 + 5, act_act[a1 + 5], 1);
    check("s1_first_read", a1 + 5, act_rdaddr[a1 + 5], 32'h100);
    check("s1_last_read", a1 + 7, act_rdaddr[a1 + 7], 32'h102);
    check("s1_read_to_write", a1, first_cycle(2, a1, a1 + 20) - first_cycle(1, a1, a1 + 20), 10);
    check("s1_first_write_addr", a1 + 15, act_wraddr[a1 + 15], 32'h20);
    check("s1_last_write_addr", a1 + 17, act_wraddr[a1 + 17], 32'h22);
    check("s1_done_count", a1, cnt(3, a1, a1 + 19), 1);
    check("s1_done_cycle", a1 + 18, act_done[a1 + 18], 1);
    // Scenario 2: three stall cycles at k=1.
    check("s2_stall_count", a2, cnt(4, a2, a2 + 8), 3);
    check("s2_waddr_hold", a2 + 3, act_waddr[a2 + 3], 1);
    check("s2_first_read_offset", a2, first_cycle(1, a2, a2 + 20) - a2, 8);
    check("s2_done_cycle", a2 + 21, act_done[a2 + 21], 1);
    check("s2_busy_cycles", a2, cnt(6, a2, d2), 21);
    // Scenario 3: reuse, address wrap.
    check("s3_read0", a3 + 1, act_rdaddr[a3 + 1], 32'hFFFFFF);
    check("s3_read1_wrap", a3 + 2, act_rdaddr[a3 + 2], 32'h0);
    check("s3_write0", a3 + 11, act_wraddr[a3 + 11], 32'hFFFF);
    check("s3_write1_wrap", a3 + 12, act_wraddr[a3 + 12], 32'h0);
    check("s3_no_load", a3, cnt(0, a3, d3), 0);
    check("s3_no_activate", a3, cnt(5, a3, d3), 0);
    // Scenario 4: zero length, reuse.
    check("s4_done_cycle", a4 + 1, act_done[a4 + 1], 1);
    check("s4_no_reads", a4, cnt(1, a4, a4 + 1), 0);
    // Zero length with weight load.
    check("s6_done_cycle", a6 + 5, act_done[a6 + 5], 1);
    check("s6_no_activate", a6, cnt(5, a6, a6 + 5), 0);
    // Scenario 5: reset mid-compute.
    check("s5_read_cut", a5 + 2, act_rd[a5 + 2], 0);
    check("s5_no_writes", a5, cnt(2, a5, a5 + 24), 0);
    check("s5_no_done", a5, cnt(3, a5, a5 + 24), 0);
    check("s5_ready_after_reset", a5 + 4, act_ready[a5 + 4], 1);
`ifdef MMU_SEQ_PERF_EN
    check("perf_s2_stall", d2 + 1, act_pstall[d2 + 1] - act_pstall[a2], 3);
    check("perf_s2_busy", d2 + 1, act_pbusy[d2 + 1] - act_pbusy[a2], cnt(6, a2, d2));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
